// File: rtl/mef_acesso_pkg.sv
// Purpose: shared state encoding, light bundle and width helper for the parking access controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mef_acesso_pkg;

    // 3-bit state encoding; value 7 is illegal and recovers to EST_I.
    typedef enum logic [2:0] {
        EST_I = 3'd0,   // idle
        EST_S = 3'd1,   // password entry
        EST_A = 3'd2,   // access granted, gate open
        EST_P = 3'd3,   // vehicle in passage
        EST_E = 3'd4,   // wrong password, retry allowed
        EST_C = 3'd5,   // lot full
        EST_B = 3'd6    // retry lockout
    } estado_t;

    typedef struct packed {
        logic erro;
        logic stop;
        logic go;
        logic full;
        logic bloq;
        logic in_pasw;
    } luzes_t;

    // Bits needed to hold values 0..maximo (at least one bit).
    function automatic int largura_contagem(input int maximo);
        return (maximo < 1) ? 1 : $clog2(maximo + 1);
    endfunction

    function automatic luzes_t decodifica_luzes(input estado_t e);
        luzes_t l;
        l         = '0;
        l.erro    = (e == EST_E);
        l.stop    = (e == EST_P);
        l.go      = (e == EST_A);
        l.full    = (e == EST_C);
        l.bloq    = (e == EST_B);
        l.in_pasw = (e == EST_S) || (e == EST_E);
        return l;
    endfunction

endpackage

// File: rtl/contador_ocupacao.sv
// Purpose: saturating occupancy counter; +1 on inc, -1 on each rising edge of Ss.
// Latency: count updates on the edge that samples inc / the Ss edge.
// Backpressure: none; saturates at 0 and CAPACIDADE instead of wrapping.
//
// Ports: clk, rst (sync, active-high), inc (vehicle admitted), Ss (exit sensor level),
//        contagem (current occupancy), cheio (contagem == CAPACIDADE).
module contador_ocupacao
    import mef_acesso_pkg::*;
#(
    parameter int   CAPACIDADE = 8,
    localparam int  W          = largura_contagem(CAPACIDADE)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         Ss,
    output logic [W-1:0] contagem,
    output logic         cheio
);

    localparam logic [W-1:0] CAP_W = W'(CAPACIDADE);

    logic ss_q;
    logic dec;

    // ss_q resets to 0, so an Ss already high at reset release looks like an edge;
    // it lands on a freshly cleared count and saturates away harmlessly.
    assign dec   = Ss && !ss_q;
    assign cheio = (contagem == CAP_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q     <= 1'b0;
            contagem <= '0;
        end else begin
            ss_q <= Ss;
            if (inc && !dec && (contagem != CAP_W)) begin
                contagem <= contagem + W'(1);
            end else if (dec && !inc && (contagem != '0)) begin
                contagem <= contagem - W'(1);
            end
        end
    end

endmodule

// File: rtl/mef_controle_acesso.sv
// Purpose: parking-entrance access FSM with password retry lockout, session timeout and occupancy tracking.
// Latency: one clock from sampled input to light change; lights are registered.
// Backpressure: none; OK/ERRO pulses outside S/E are dropped, all inputs except Ss ignored in lockout.
//
// Ports: clk, rst (sync, active-high); Se/Si/Ss entry/passage/exit sensors; IN keypad activity;
//        ERRO/OK checker verdict pulses; STERRO/STSTOP/STGO/STFULL/STBLOQ/IN_PASW lights;
//        OCUPACAO current occupancy.
module mef_controle_acesso
    import mef_acesso_pkg::*;
#(
    parameter int CAPACIDADE      = 8,
    parameter int MAX_TENTATIVAS  = 3,
    parameter int TIMEOUT_CICLOS  = 16,
    parameter int BLOQUEIO_CICLOS = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     Se,
    input  logic                                     Si,
    input  logic                                     Ss,
    input  logic                                     IN,
    input  logic                                     ERRO,
    input  logic                                     OK,
    output logic                                     STERRO,
    output logic                                     STSTOP,
    output logic                                     STGO,
    output logic                                     STFULL,
    output logic                                     STBLOQ,
    output logic                                     IN_PASW,
    output logic [largura_contagem(CAPACIDADE)-1:0]  OCUPACAO
);

    localparam int WT = largura_contagem(TIMEOUT_CICLOS);
    localparam int WA = largura_contagem(MAX_TENTATIVAS);
    localparam int WB = largura_contagem(BLOQUEIO_CICLOS);

    localparam logic [WT-1:0] TEMPO_FIM = WT'(TIMEOUT_CICLOS - 1);
    localparam logic [WA-1:0] TENT_MAX  = WA'(MAX_TENTATIVAS);
    localparam logic [WB-1:0] BLOQ_FIM  = WB'(BLOQUEIO_CICLOS - 1);

    estado_t         estado;
    estado_t         prox;
    luzes_t          luzes;
    logic [WT-1:0]   tempo;
    logic [WA-1:0]   tentativas;
    logic [WB-1:0]   bloq;

    logic            tempo_zera;
    logic            tent_inc;
    logic            tent_zera;
    logic            expirou;
    logic            cheio;
    logic            entra;

    assign expirou = (tempo == TEMPO_FIM);
    // P->I admits the vehicle; the occupancy counter moves on the same edge.
    assign entra   = (estado == EST_P) && !Si;

    contador_ocupacao #(
        .CAPACIDADE (CAPACIDADE)
    ) u_ocupacao (
        .clk      (clk),
        .rst      (rst),
        .inc      (entra),
        .Ss       (Ss),
        .contagem (OCUPACAO),
        .cheio    (cheio)
    );

    // Next state and counter controls. The timer is held at zero outside S/E/A,
    // so every entry into those states starts from a clean count.
    always_comb begin
        prox       = EST_I;
        tempo_zera = 1'b1;
        tent_inc   = 1'b0;
        tent_zera  = 1'b0;
        case (estado)
            EST_I: begin
                if (cheio)   prox = EST_C;
                else if (Se) prox = EST_S;
                else         prox = EST_I;
            end
            EST_C: begin
                prox = cheio ? EST_C : EST_I;
            end
            EST_S, EST_E: begin
                tempo_zera = IN;
                if (OK) begin
                    prox       = EST_A;
                    tempo_zera = 1'b1;
                    tent_zera  = 1'b1;
                end else if (ERRO) begin
                    tent_inc   = 1'b1;
                    tempo_zera = 1'b1;
                    prox       = ((tentativas + WA'(1)) == TENT_MAX) ? EST_B : EST_E;
                end else if (!Se || expirou) begin
                    prox = EST_I;
                end else begin
                    prox = estado;
                end
            end
            EST_A: begin
                // Only an empty approach (no vehicle at gate or under it) runs the timer.
                tempo_zera = IN || Se || Si;
                if (Si)                   prox = EST_P;
                else if (!Se && expirou)  prox = EST_I;
                else                      prox = EST_A;
            end
            EST_P: begin
                prox = Si ? EST_P : EST_I;
            end
            EST_B: begin
                if (bloq == BLOQ_FIM) begin
                    prox      = EST_I;
                    tent_zera = 1'b1;
                end else begin
                    prox = EST_B;
                end
            end
            default: begin
                prox = EST_I;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado     <= EST_I;
            luzes      <= '0;
            tempo      <= '0;
            tentativas <= '0;
            bloq       <= '0;
        end else begin
            estado <= prox;
            luzes  <= decodifica_luzes(prox);
            tempo  <= tempo_zera ? '0 : tempo + WT'(1);
            if (tent_zera) begin
                tentativas <= '0;
            end else if (tent_inc) begin
                tentativas <= tentativas + WA'(1);
            end
            bloq <= ((estado == EST_B) && (prox == EST_B)) ? bloq + WB'(1) : '0;
        end
    end

    assign STERRO  = luzes.erro;
    assign STSTOP  = luzes.stop;
    assign STGO    = luzes.go;
    assign STFULL  = luzes.full;
    assign STBLOQ  = luzes.bloq;
    assign IN_PASW = luzes.in_pasw;

endmodule

// File: tb/tb_mef_controle_acesso.sv
module tb_mef_controle_acesso;

    // Input bundle bits: {rst, Se, Si, Ss, IN, ERRO, OK}
    localparam logic [6:0] R   = 7'b1000000;
    localparam logic [6:0] SE  = 7'b0100000;
    localparam logic [6:0] SI  = 7'b0010000;
    localparam logic [6:0] SS  = 7'b0001000;
    localparam logic [6:0] INK = 7'b0000100;
    localparam logic [6:0] ER  = 7'b0000010;
    localparam logic [6:0] OKP = 7'b0000001;
    localparam logic [6:0] NADA = 7'b0000000;

    // Expected lights: {STERRO, STSTOP, STGO, STFULL, STBLOQ, IN_PASW}
    localparam logic [5:0] L_I = 6'b000000;
    localparam logic [5:0] L_S = 6'b000001;
    localparam logic [5:0] L_E = 6'b100001;
    localparam logic [5:0] L_A = 6'b001000;
    localparam logic [5:0] L_P = 6'b010000;
    localparam logic [5:0] L_C = 6'b000100;
    localparam logic [5:0] L_B = 6'b000010;

    typedef struct {
        logic [6:0] ent;
        logic       d2;
        logic [5:0] luz;
        int         ocup;
    } vec_t;

    logic clk = 1'b0;
    logic rst, se, si, ss, in_k, erro, ok;

    logic       e1, p1, g1, f1, b1, k1;
    logic [3:0] oc1;
    logic       e2, p2, g2, f2, b2, k2;
    logic [1:0] oc2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mef_controle_acesso dut (
        .clk(clk), .rst(rst), .Se(se), .Si(si), .Ss(ss), .IN(in_k), .ERRO(erro), .OK(ok),
        .STERRO(e1), .STSTOP(p1), .STGO(g1), .STFULL(f1), .STBLOQ(b1), .IN_PASW(k1),
        .OCUPACAO(oc1)
    );

    mef_controle_acesso #(.CAPACIDADE(2)) dut2 (
        .clk(clk), .rst(rst), .Se(se), .Si(si), .Ss(ss), .IN(in_k), .ERRO(erro), .OK(ok),
        .STERRO(e2), .STSTOP(p2), .STGO(g2), .STFULL(f2), .STBLOQ(b2), .IN_PASW(k2),
        .OCUPACAO(oc2)
    );

    function automatic vec_t v(input logic [6:0] ent, input logic d2,
                               input logic [5:0] luz, input int ocup);
        vec_t r;
        r.ent  = ent;
        r.d2   = d2;
        r.luz  = luz;
        r.ocup = ocup;
        return r;
    endfunction

    // Drive one cycle of inputs, let the edge happen, then compare 1 time unit later.
    task automatic passo(input logic [6:0] ent, input logic d2, input logic [5:0] luz,
                         input int ocup, input string nome);
        logic [5:0] luz_dut;
        int         oc_dut;
        {rst, se, si, ss, in_k, erro, ok} = ent;
        @(posedge clk);
        #1;
        if (d2) begin
            luz_dut = {e2, p2, g2, f2, b2, k2};
            oc_dut  = int'(oc2);
        end else begin
            luz_dut = {e1, p1, g1, f1, b1, k1};
            oc_dut  = int'(oc1);
        end
        checks++;
        if (luz_dut !== luz || oc_dut != ocup) begin
            errors++;
            $display("FAIL %s: lights=%b occ=%0d, expected lights=%b occ=%0d",
                     nome, luz_dut, oc_dut, luz, ocup);
        end
    endtask

    vec_t tab[$];

    initial begin
        {rst, se, si, ss, in_k, erro, ok} = 7'b1000000;

        // Admission, stray verdicts, then three wrong passwords into lockout.
        tab.push_back(v(R,        0, L_I, 0));
        tab.push_back(v(R,        0, L_I, 0));
        tab.push_back(v(SE,       0, L_S, 0));
        tab.push_back(v(SE | OKP, 0, L_A, 0));
        tab.push_back(v(SE,       0, L_A, 0));
        tab.push_back(v(SI,       0, L_P, 0));
        tab.push_back(v(SI,       0, L_P, 0));
        tab.push_back(v(SI,       0, L_P, 0));
        tab.push_back(v(NADA,     0, L_I, 1));
        tab.push_back(v(OKP,      0, L_I, 1));
        tab.push_back(v(ER,       0, L_I, 1));
        tab.push_back(v(SE,       0, L_S, 1));
        tab.push_back(v(SE | ER,  0, L_E, 1));
        tab.push_back(v(SE,       0, L_E, 1));
        tab.push_back(v(SE | ER,  0, L_E, 1));
        tab.push_back(v(SE | ER,  0, L_B, 1));
        for (int i = 0; i < tab.size(); i++) begin
            passo(tab[i].ent, tab[i].d2, tab[i].luz, tab[i].ocup, $sformatf("tab1_%0d", i));
        end

        // Lockout lasts 32 cycles in total; verdicts ignored, Ss edge still counted.
        for (int i = 0; i < 31; i++) begin
            logic [6:0] ent;
            ent = SE;
            if (i == 5) ent = ent | OKP;
            if (i == 6) ent = ent | ER;
            if (i == 10 || i == 11) ent = ent | SS;
            passo(ent, 0, L_B, (i < 10) ? 1 : 0, $sformatf("bloq_%0d", i));
        end
        passo(SE, 0, L_I, 0, "bloq_fim");

        // Attempts were cleared on lockout exit: needs three fresh errors again.
        passo(SE,      0, L_S, 0, "retry_s");
        passo(SE | ER, 0, L_E, 0, "retry_e1");
        passo(SE | ER, 0, L_E, 0, "retry_e2");
        passo(SE | ER, 0, L_B, 0, "retry_b");
        passo(R | SE,  0, L_I, 0, "rst_em_b");

        // Session timeout in S: exactly 16 cycles after entry.
        passo(SE, 0, L_S, 0, "to_entra");
        for (int j = 1; j <= 16; j++) begin
            passo(SE, 0, (j == 16) ? L_I : L_S, 0, $sformatf("to_s_%0d", j));
        end
        // Keypad activity every 10 cycles keeps the session alive.
        passo(SE, 0, L_S, 0, "in_entra");
        for (int j = 1; j <= 40; j++) begin
            passo(SE | ((j % 10 == 0) ? INK : NADA), 0, L_S, 0, $sformatf("in_s_%0d", j));
        end
        // Abandoned access: no vehicle at gate or under it for 16 cycles.
        passo(SE | OKP, 0, L_A, 0, "to_a_entra");
        for (int j = 1; j <= 16; j++) begin
            passo(NADA, 0, (j == 16) ? L_I : L_A, 0, $sformatf("to_a_%0d", j));
        end

        // Reset during passage clears occupancy.
        passo(SE,       0, L_S, 0, "rp_s1");
        passo(SE | OKP, 0, L_A, 0, "rp_a1");
        passo(SI,       0, L_P, 0, "rp_p1");
        passo(NADA,     0, L_I, 1, "rp_i1");
        passo(SE,       0, L_S, 1, "rp_s2");
        passo(SE | OKP, 0, L_A, 1, "rp_a2");
        passo(SI,       0, L_P, 1, "rp_p2");
        passo(R | SI,   0, L_I, 0, "rst_em_p");

        // Capacity 2: fill, full ignores Se, exit frees a space, coincident in/out.
        tab.delete();
        tab.push_back(v(R,        1, L_I, 0));
        tab.push_back(v(SE,       1, L_S, 0));
        tab.push_back(v(SE | OKP, 1, L_A, 0));
        tab.push_back(v(SI,       1, L_P, 0));
        tab.push_back(v(NADA,     1, L_I, 1));
        tab.push_back(v(SE,       1, L_S, 1));
        tab.push_back(v(SE | OKP, 1, L_A, 1));
        tab.push_back(v(SI,       1, L_P, 1));
        tab.push_back(v(NADA,     1, L_I, 2));
        tab.push_back(v(SE,       1, L_C, 2));
        tab.push_back(v(SE,       1, L_C, 2));
        tab.push_back(v(SE | SS,  1, L_C, 1));
        tab.push_back(v(SE | SS,  1, L_I, 1));
        tab.push_back(v(SE,       1, L_S, 1));
        tab.push_back(v(SE | OKP, 1, L_A, 1));
        tab.push_back(v(SI,       1, L_P, 1));
        tab.push_back(v(SS,       1, L_I, 1));
        tab.push_back(v(NADA,     1, L_I, 1));
        tab.push_back(v(SS,       1, L_I, 0));
        tab.push_back(v(NADA,     1, L_I, 0));
        tab.push_back(v(SS,       1, L_I, 0));
        tab.push_back(v(R | SS,   1, L_I, 0));
        tab.push_back(v(SS,       1, L_I, 0));
        for (int i = 0; i < tab.size(); i++) begin
            passo(tab[i].ent, tab[i].d2, tab[i].luz, tab[i].ocup, $sformatf("tab2_%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
